// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access size, FSM state,
// and the byte-lane mask used for stores that may straddle two RAM words.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int MAX_NB = 8;

    // Mask spans two words so the upper half describes the second beat of a split access.
    function automatic logic [2*MAX_NB-1:0] lane_mask(input size_e size, input logic [2:0] offset);
        logic [4:0]          nbytes;
        logic [2*MAX_NB-1:0] m;
        nbytes = 5'd1 << size;
        m      = (16'd1 << nbytes) - 16'd1;
        return m << offset;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port byte-writable RAM with a registered read; maps onto an inferred block RAM.
// A read during a write to the same word returns the old contents.
module dmem_bram #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 15,
   parameter     INIT_FILE = ""
) (
   input  logic                i_clk,
   input  logic [DATA_W/8-1:0] i_be,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic [DATA_W-1:0]   o_rdata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] r_mem [0:2**ADDR_W-1];

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NB; i++) begin
         if (i_be[i]) begin
            r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
         end
      end
      o_rdata <= r_mem[i_addr];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready requests, byte-lane stores, extended loads,
// two-beat splitting of word-crossing accesses and out-of-range rejection.
//
// state | meaning
// IDLE  | ready for a request; first RAM beat issued on accept
// SPLIT | second beat to word W+1 of a word-crossing access
// RESP  | one-cycle response pulse, load data merged and extended
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 15,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int          NB    = DATA_W / 8;
    localparam int          OFF_W = $clog2(NB);
    localparam int          MW    = 2 * NB;
    localparam logic [32:0] LIMIT = 33'(NB) << ADDR_W;

    state_e              r_state;
    state_e              w_state_nxt;

    logic [ADDR_W-1:0]   r_word_hi;
    logic [OFF_W-1:0]    r_off;
    size_e               r_size;
    logic                r_unsigned;
    logic                r_we;
    logic                r_err;
    logic                r_split;
    logic [NB-1:0]       r_hi_be;
    logic [DATA_W-1:0]   r_hi_data;
    logic [DATA_W-1:0]   r_lo;

    logic [OFF_W-1:0]    w_off;
    logic [ADDR_W-1:0]   w_word;
    logic [3:0]          w_bytes;
    logic [4:0]          w_end;
    logic                w_split;
    logic [32:0]         w_last;
    logic                w_err;
    logic                w_idle;
    logic                w_accept;
    logic [MW-1:0]       w_mask;
    logic [2*DATA_W-1:0] w_wdata_sh;

    logic [NB-1:0]       w_ram_be;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [DATA_W-1:0]   w_ram_rdata;

    logic [2*DATA_W-1:0] w_rd_wide;
    logic [DATA_W-1:0]   w_rd_al;
    logic                w_sign;
    logic [DATA_W-1:0]   w_rd_ext;

    assign w_off      = req_addr[OFF_W-1:0];
    assign w_word     = req_addr[ADDR_W+OFF_W-1:OFF_W];
    assign w_bytes    = 4'd1 << req_size;
    assign w_end      = 5'(w_off) + 5'(w_bytes);
    assign w_split    = w_end > 5'(NB);
    // Last touched byte in 33 bits so an access near 4 GiB cannot wrap into range.
    assign w_last     = {1'b0, req_addr} + 33'(w_bytes) - 33'd1;
    assign w_err      = (w_bytes > 4'(NB)) || (w_last >= LIMIT);
    assign w_idle     = (r_state == IDLE);
    assign w_accept   = req_valid && rst_n && w_idle;
    assign w_mask     = MW'(lane_mask(size_e'(req_size), 3'(w_off)));
    assign w_wdata_sh = {{DATA_W{1'b0}}, req_wdata} << {w_off, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_split && !w_err) ? SPLIT : RESP;
            SPLIT:   w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Beat 1 is driven straight from the request; beat 2 from the captured upper half.
    always_comb begin
        resp_valid  = 1'b0;
        w_ram_be    = '0;
        w_ram_addr  = w_word;
        w_ram_wdata = w_wdata_sh[DATA_W-1:0];
        case (r_state)
            IDLE: begin
                if (w_accept && req_we && !w_err) w_ram_be = w_mask[NB-1:0];
            end
            SPLIT: begin
                w_ram_addr  = r_word_hi;
                w_ram_wdata = r_hi_data;
                if (rst_n && r_we) w_ram_be = r_hi_be;
            end
            RESP: begin
                resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready = w_idle && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word_hi  <= '0;
            r_off      <= '0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_split    <= 1'b0;
            r_hi_be    <= '0;
            r_hi_data  <= '0;
            r_lo       <= '0;
        end else begin
            if (w_accept) begin
                r_word_hi  <= w_word + ADDR_W'(1);
                r_off      <= w_off;
                r_size     <= size_e'(req_size);
                r_unsigned <= req_unsigned;
                r_we       <= req_we;
                r_err      <= w_err;
                r_split    <= w_split && !w_err;
                r_hi_be    <= w_mask[MW-1:NB];
                r_hi_data  <= w_wdata_sh[2*DATA_W-1:DATA_W];
            end
            if (r_state == SPLIT) begin
                r_lo <= w_ram_rdata;
            end
        end
    end

    dmem_bram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .i_clk   (clk),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_rd_wide = r_split ? {w_ram_rdata, r_lo} : {{DATA_W{1'b0}}, w_ram_rdata};
    assign w_rd_al   = DATA_W'(w_rd_wide >> {r_off, 3'b000});

    always_comb begin
        w_sign   = 1'b0;
        w_rd_ext = '0;
        case (r_size)
            SZ_B:    w_sign = w_rd_al[7];
            SZ_H:    w_sign = w_rd_al[15];
            SZ_W:    w_sign = w_rd_al[31];
            default: w_sign = w_rd_al[DATA_W-1];
        endcase
        for (int i = 0; i < NB; i++) begin
            w_rd_ext[i*8 +: 8] = (i < (1 << r_size)) ? w_rd_al[i*8 +: 8]
                                                     : {8{w_sign && !r_unsigned}};
        end
    end

    assign resp_rdata = (r_state == RESP && !r_err && !r_we) ? w_rd_ext : '0;
    assign resp_err   = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (DATA_W=32, ADDR_W=15): a table of single accesses
// followed by hand-written back-to-back and reset-during-split sequences.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_vec = 0;
    int n_err = 0;

    dmem_ctrl #(.DATA_W(32), .ADDR_W(15), .INIT_FILE("")) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following the response.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic err, output int lat,
                           output logic pulse_ok, output logic got);
        int t;
        got = 1'b0; rd = '0; err = 1'b0; lat = 0; pulse_ok = 1'b0;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!resp_valid) return;
        got = 1'b1;
        rd  = resp_rdata;
        err = resp_err;
        @(posedge clk); #1;
        pulse_ok = !resp_valid;
    endtask

    task automatic do_vec(input int idx, input vec_t v);
        logic [31:0] rd;
        logic        err, pulse_ok, got;
        int          lat;
        run_req(v.we, v.size, v.uns, v.addr, v.wdata, rd, err, lat, pulse_ok, got);
        chk("handshake", idx, 64'(got), 64'd1);
        if (got) begin
            chk("rdata", idx, 64'(rd), 64'(v.exp_rd));
            chk("err", idx, 64'(err), 64'(v.exp_err));
            chk("latency", idx, 64'(lat), 64'(v.exp_lat));
            chk("pulse", idx, 64'(pulse_ok), 64'd1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        logic [5:0]  rdy_pat;
        logic        seen_valid, seen_ready;

        //        we    sz    uns   addr           wdata          exp_rd         err   lat
        vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1));
        vt.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_0055, 32'h0000_0000, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_55EF, 1'b0, 1));
        vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0000_000C, 32'h0102_0304, 32'h0000_0000, 1'b0, 1));
        vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0000_000E, 32'h1122_3344, 32'h0000_0000, 1'b0, 2));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0,         32'h3344_0304, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_1122, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_000E, 32'h0,         32'h1122_3344, 1'b0, 2));
        vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0000_0014, 32'h8070_6050, 32'h0000_0000, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_50DE, 1'b0, 2));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_0012, 32'h0,         32'h6050_DEAD, 1'b0, 2));
        vt.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0000_0016, 32'h0,         32'hFFFF_8070, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_0014, 32'h0,         32'h0000_0050, 1'b0, 1));
        vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0001_FFFC, 32'h1234_5678, 32'h0000_0000, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'h0,         32'h0000_0000, 1'b1, 1));
        vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0001_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0001_FFFC, 32'h0,         32'h1234_5678, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd0, 1'b1, 32'h0001_FFFF, 32'h0,         32'h0000_0012, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0001_FFFF, 32'h0,         32'h0000_0000, 1'b1, 1));
        vt.push_back(mk(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 1));
        vt.push_back(mk(1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_1122, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1, 1));
        vt.push_back(mk(1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 1));
        vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEBE_EF22, 1'b0, 1));

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 0, 64'(req_ready), 64'd0);
        chk("rst_valid", 0, 64'(resp_valid), 64'd0);
        chk("rst_rdata", 0, 64'(resp_rdata), 64'd0);
        chk("rst_err", 0, 64'(resp_err), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 0, 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        foreach (vt[i]) do_vec(i, vt[i]);

        // Back-to-back aligned loads with req_valid held high.
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = '0;
        req_valid = 1'b1; rdy_pat = '0; pulses = 0;
        for (int i = 0; i < 6; i++) begin
            rdy_pat[i] = req_ready;
            if (resp_valid) begin
                pulses++;
                chk("b2b_rdata", i, 64'(resp_rdata), 64'hDEBE_EF22);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("b2b_ready", 0, 64'(rdy_pat), 64'b010101);
        chk("b2b_pulses", 0, 64'(pulses), 64'd3);
        @(posedge clk); #1;
        chk("b2b_tail", 0, 64'(resp_valid), 64'd0);

        // Back-to-back split loads.
        req_addr = 32'h0E; req_valid = 1'b1; rdy_pat = '0; pulses = 0;
        for (int i = 0; i < 6; i++) begin
            rdy_pat[i] = req_ready;
            if (resp_valid) begin
                pulses++;
                chk("b2b_split_rdata", i, 64'(resp_rdata), 64'hEF22_3344);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("b2b_split_ready", 0, 64'(rdy_pat), 64'b001001);
        chk("b2b_split_pulses", 0, 64'(pulses), 64'd2);
        @(posedge clk); #1;

        // Reset asserted while a split store sits in SPLIT.
        do_vec(100, mk(1'b1, 2'd2, 1'b0, 32'h1C, 32'h1111_1111, 32'h0, 1'b0, 1));
        do_vec(101, mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h2222_2222, 32'h0, 1'b0, 1));
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h1E; req_wdata = 32'hAABB_CCDD;
        req_valid = 1'b1;
        chk("rst_split_ready_pre", 0, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        seen_valid = 1'b0; seen_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen_valid |= resp_valid;
            seen_ready |= req_ready;
            @(posedge clk); #1;
        end
        chk("rst_split_no_resp", 0, 64'(seen_valid), 64'd0);
        chk("rst_split_no_ready", 0, 64'(seen_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_split_ready_post", 0, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        do_vec(102, mk(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, 32'hCCDD_1111, 1'b0, 1));
        do_vec(103, mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h2222_2222, 1'b0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
